// File: rtl/listo_pkg.sv
// Shared register offsets, reset constants and helpers for the done-flag
// register block.
package listo_pkg;

   localparam int OFF_STATUS  = 0;
   localparam int OFF_MASK    = 1;
   localparam int OFF_PENDING = 2;
   localparam int OFF_COUNT   = 3;
   localparam int OFF_OVERRUN = 4;

   localparam logic        RST_FLAG = 1'b0;
   localparam logic [31:0] RST_WORD = 32'd0;

   typedef enum logic [2:0] {
      SEL_STATUS,
      SEL_MASK,
      SEL_PENDING,
      SEL_COUNT,
      SEL_OVERRUN,
      SEL_NONE
   } reg_sel_e;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + 5'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/registro_listo_multi_if.sv
// Single-cycle register bus between a host and the done-flag register block.
interface registro_listo_multi_if #(
   parameter int ADDR_W = 9
);
   logic              Write;
   logic              Read;
   logic [ADDR_W-1:0] Address;
   logic [31:0]       WriteData;
   logic [31:0]       ReadData;
   logic              ReadValid;

   modport master (
      output Write, Read, Address, WriteData,
      input  ReadData, ReadValid
   );

   modport slave (
      input  Write, Read, Address, WriteData,
      output ReadData, ReadValid
   );
endinterface

// File: rtl/listo_flag_cell.sv
// One sticky flag bit: set has priority over a write-1-to-clear in the same
// cycle, so no event is ever lost.
module listo_flag_cell
   import listo_pkg::*;
(
   input  logic CLK,
   input  logic ResetMaster,
   input  logic set,
   input  logic clr,
   output logic q
);

   logic q_reg;
   logic q_next;

   always_comb begin
      q_next = set | (q_reg & ~clr);
   end

   always_ff @(posedge CLK) begin
      if (ResetMaster) begin
         q_reg <= RST_FLAG;
      end else begin
         q_reg <= q_next;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/registro_listo_multi.sv
// Multi-channel done-flag register block: sticky STATUS/OVERRUN flags, MASK,
// PENDING, saturating completion COUNT and a registered interrupt.
module registro_listo_multi
   import listo_pkg::*;
#(
   parameter int          NUM_CH    = 4,
   parameter int          ADDR_W    = 9,
   parameter int unsigned BASE_ADDR = 'h184,
   parameter int          CNT_W     = 8
) (
   input  logic                  CLK,
   input  logic                  ResetMaster,
   registro_listo_multi_if.slave bus,
   input  logic [NUM_CH-1:0]     EnableListo,
   output logic [NUM_CH-1:0]     Out,
   output logic                  Irq
);

   localparam int SUM_W = CNT_W + 5;

   logic [NUM_CH-1:0] status_q;
   logic [NUM_CH-1:0] overrun_q;
   logic [NUM_CH-1:0] status_clr;
   logic [NUM_CH-1:0] overrun_clr;
   logic [NUM_CH-1:0] overrun_set;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] mask_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_base;
   logic [CNT_W-1:0]  count_next;
   logic [SUM_W-1:0]  count_sum;
   logic              irq_reg;
   logic              rvalid_reg;
   logic [31:0]       rdata_reg;
   logic [31:0]       rd_word;
   logic [ADDR_W-1:0] offset;
   reg_sel_e          sel;
   logic              wr_status;
   logic              wr_mask;
   logic              wr_count;
   logic              wr_overrun;
   logic              unused_wdata;

   assign unused_wdata = ^bus.WriteData;

   // Offsets are relative to BASE_ADDR so one decoder serves any base.
   assign offset = bus.Address - ADDR_W'(BASE_ADDR);

   always_comb begin
      sel = SEL_NONE;
      case (offset)
         ADDR_W'(OFF_STATUS):  sel = SEL_STATUS;
         ADDR_W'(OFF_MASK):    sel = SEL_MASK;
         ADDR_W'(OFF_PENDING): sel = SEL_PENDING;
         ADDR_W'(OFF_COUNT):   sel = SEL_COUNT;
         ADDR_W'(OFF_OVERRUN): sel = SEL_OVERRUN;
         default:              sel = SEL_NONE;
      endcase
   end

   assign wr_status  = bus.Write && (sel == SEL_STATUS);
   assign wr_mask    = bus.Write && (sel == SEL_MASK);
   assign wr_count   = bus.Write && (sel == SEL_COUNT);
   assign wr_overrun = bus.Write && (sel == SEL_OVERRUN);

   assign status_clr  = wr_status  ? bus.WriteData[NUM_CH-1:0] : '0;
   assign overrun_clr = wr_overrun ? bus.WriteData[NUM_CH-1:0] : '0;
   // A repeat event on an already-set flag is an overrun unless software is
   // acknowledging that same flag this cycle.
   assign overrun_set = EnableListo & status_q & ~status_clr;
   assign pending     = status_q & mask_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         listo_flag_cell u_status (
            .CLK         (CLK),
            .ResetMaster (ResetMaster),
            .set         (EnableListo[gi]),
            .clr         (status_clr[gi]),
            .q           (status_q[gi])
         );
         listo_flag_cell u_overrun (
            .CLK         (CLK),
            .ResetMaster (ResetMaster),
            .set         (overrun_set[gi]),
            .clr         (overrun_clr[gi]),
            .q           (overrun_q[gi])
         );
      end
   endgenerate

   // A COUNT write replaces the base; this cycle's events still land on top.
   always_comb begin
      count_base = wr_count ? bus.WriteData[CNT_W-1:0] : count_reg;
      count_sum  = SUM_W'(count_base) + SUM_W'(popcount16(16'(EnableListo)));
      count_next = (count_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                        : count_sum[CNT_W-1:0];
   end

   always_comb begin
      rd_word = RST_WORD;
      case (sel)
         SEL_STATUS:  rd_word = 32'(status_q);
         SEL_MASK:    rd_word = 32'(mask_reg);
         SEL_PENDING: rd_word = 32'(pending);
         SEL_COUNT:   rd_word = 32'(count_reg);
         SEL_OVERRUN: rd_word = 32'(overrun_q);
         default:     rd_word = RST_WORD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (ResetMaster) begin
         mask_reg   <= RST_WORD[NUM_CH-1:0];
         count_reg  <= RST_WORD[CNT_W-1:0];
         irq_reg    <= RST_FLAG;
         rvalid_reg <= RST_FLAG;
         rdata_reg  <= RST_WORD;
      end else begin
         if (wr_mask) begin
            mask_reg <= bus.WriteData[NUM_CH-1:0];
         end
         count_reg  <= count_next;
         irq_reg    <= |pending;
         rvalid_reg <= bus.Read;
         if (bus.Read) begin
            rdata_reg <= rd_word;
         end
      end
   end

   assign bus.ReadData  = rdata_reg;
   assign bus.ReadValid = rvalid_reg;
   assign Out           = status_q;
   assign Irq           = irq_reg;

endmodule
